// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the downstream core in reset until the PLL lock
// indicator has been stable for STABLE_CYCLES clocks. It then releases core_rst
// and generates a sample-rate clock-enable strobe.
// Latency: core_rst falls SYNC_STAGES+STABLE_CYCLES+1 edges after locked is
// first sampled high. The first sample_ce follows CE_DIV cycles later.
// Backpressure: none. The block has no handshake and every output is a registered level/strobe.
//
// Ports:
//   clk        in   single clock (PLL outclk_0 domain)
//   rst        in   synchronous active-high reset
//   locked     in   PLL lock indicator, asynchronous to clk
//   clr_lost   in   synchronous clear of lock_lost (and lost_count)
//   core_rst   out  registered active-high reset for the downstream core
//   sample_ce  out  registered one-cycle strobe every CE_DIV cycles while running
//   lock_lost  out  sticky flag: lock dropped while running
//   lost_count out  saturating lock-loss counter
//
// Optional feature: define PLL_SEQ_LOSS_CNT_EN to build the lost_count counter.
// Without it, lost_count is tied to zero.

module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int CE_DIV        = 768
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  input  logic       clr_lost,
  output logic       core_rst,
  output logic       sample_ce,
  output logic       lock_lost,
  output logic [7:0] lost_count
);

  localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int DIV_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
  localparam logic [1:0] ST_STABLE    = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0]             state_q, state_d;
  logic [STB_W-1:0]       stb_cnt_q, stb_cnt_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic                   core_rst_q, core_rst_d;
  logic                   sample_ce_q, sample_ce_d;
  logic                   lock_lost_q, lock_lost_d;
  logic                   lock_s;
  logic                   loss_evt;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], locked};
    state_d     = state_q;
    stb_cnt_d   = stb_cnt_q;
    div_d       = div_q;
    loss_evt    = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d   = ST_STABLE;
          stb_cnt_d = '0;
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
        end else if (stb_cnt_q == STB_W'(STABLE_CYCLES - 1)) begin
          // Divider restarts here so the first strobe lands CE_DIV cycles
          // after core_rst falls.
          state_d = ST_RUN;
          div_d   = '0;
        end else begin
          stb_cnt_d = stb_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d  = ST_WAIT_LOCK;
          loss_evt = 1'b1;
        end else if (div_q == DIV_W'(CE_DIV - 1)) begin
          div_d = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_WAIT_LOCK;
    endcase

    // core_rst follows the next state so it changes on the same edge that
    // enters or leaves RUN.
    core_rst_d  = (state_d != ST_RUN);
    // Only strobe when RUN continues through this edge.
    sample_ce_d = (state_q == ST_RUN) && lock_s && (div_q == DIV_W'(CE_DIV - 1));
    // A loss event takes precedence over a simultaneous clear.
    lock_lost_d = loss_evt ? 1'b1 : (clr_lost ? 1'b0 : lock_lost_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= ST_WAIT_LOCK;
      stb_cnt_q   <= '0;
      div_q       <= '0;
      core_rst_q  <= 1'b1;
      sample_ce_q <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      stb_cnt_q   <= stb_cnt_d;
      div_q       <= div_d;
      core_rst_q  <= core_rst_d;
      sample_ce_q <= sample_ce_d;
      lock_lost_q <= lock_lost_d;
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] lost_cnt_q, lost_cnt_d;

  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (loss_evt) begin
      if (lost_cnt_q != 8'hFF) begin
        lost_cnt_d = lost_cnt_q + 8'd1;
      end
    end else if (clr_lost) begin
      lost_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lost_cnt_q <= 8'd0;
    end else begin
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign lost_count = lost_cnt_q;
`else
  assign lost_count = 8'd0;
`endif

  assign core_rst  = core_rst_q;
  assign sample_ce = sample_ce_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer.
// The default-parameter instance is driven from a table of hand-derived expectations.
// A small-parameter instance is driven with random lock patterns and compared every
// cycle against a behavioural model. The model counts consecutive synchronized
// lock samples.

module tb_pll_lock_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

`ifdef PLL_SEQ_LOSS_CNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif
  localparam logic [7:0] LC = (CNT_EN != 0) ? 8'd1 : 8'd0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- default-parameter instance ----------------
  logic       rst = 1'b1, locked = 1'b0, clr_lost = 1'b0;
  logic       core_rst, sample_ce, lock_lost;
  logic [7:0] lost_count;

  pll_lock_sequencer dut (
    .clk(clk), .rst(rst), .locked(locked), .clr_lost(clr_lost),
    .core_rst(core_rst), .sample_ce(sample_ce), .lock_lost(lock_lost),
    .lost_count(lost_count)
  );

  // ---------------- small-parameter instance ----------------
  localparam int SS = 3, SC = 4, CD = 5;
  logic       s_rst = 1'b1, s_locked = 1'b0, s_clr = 1'b0;
  logic       s_core_rst, s_sample_ce, s_lock_lost;
  logic [7:0] s_lost_count;

  pll_lock_sequencer #(.SYNC_STAGES(SS), .STABLE_CYCLES(SC), .CE_DIV(CD)) dut_s (
    .clk(clk), .rst(s_rst), .locked(s_locked), .clr_lost(s_clr),
    .core_rst(s_core_rst), .sample_ce(s_sample_ce), .lock_lost(s_lock_lost),
    .lost_count(s_lost_count)
  );

  // Behavioural model: lock_s is locked delayed SS edges. The block is running
  // once lock_s has been sampled high on SC+1 consecutive edges.
  logic m_q[$];
  int   m_run = 0;
  int   m_cnt = 0;
  logic m_rst = 1'b1, m_ce = 1'b0, m_lost = 1'b0;

  always @(posedge clk) begin
    logic ls, was_run, loss;
    int n;
    if (s_rst) begin
      m_q.delete();
      for (int i = 0; i < SS; i++) m_q.push_back(1'b0);
      m_run = 0; m_cnt = 0; m_lost = 1'b0; m_rst = 1'b1; m_ce = 1'b0;
    end else begin
      ls = m_q.pop_front();
      m_q.push_back(s_locked);
      was_run = (m_run >= SC + 1);
      m_run   = ls ? m_run + 1 : 0;
      loss    = was_run && !ls;
      if (loss) m_lost = 1'b1;
      else if (s_clr) m_lost = 1'b0;
      if (CNT_EN != 0) begin
        if (loss) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        else if (s_clr) m_cnt = 0;
      end
      n     = m_run - (SC + 1);
      m_rst = !(m_run >= SC + 1);
      m_ce  = (m_run >= SC + 1) && (n > 0) && (n % CD == 0);
    end
  end

  task automatic cmp_small();
    check("s_core_rst",   {31'd0, s_core_rst},  {31'd0, m_rst});
    check("s_sample_ce",  {31'd0, s_sample_ce}, {31'd0, m_ce});
    check("s_lock_lost",  {31'd0, s_lock_lost}, {31'd0, m_lost});
    check("s_lost_count", {24'd0, s_lost_count}, m_cnt);
  endtask

  // ---------------- vector table for default instance ----------------
  typedef struct {
    logic       rst, locked, clr;
    int         n;
    logic       e_rst, e_ce, e_lost;
    logic [7:0] e_cnt;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic l, input logic c, input int n,
                     input logic er, input logic ec, input logic el,
                     input logic [7:0] ecnt, input string nm);
    vec_t v;
    v.rst = r; v.locked = l; v.clr = c; v.n = n;
    v.e_rst = er; v.e_ce = ec; v.e_lost = el; v.e_cnt = ecnt; v.name = nm;
    tbl.push_back(v);
  endtask

  initial begin
    // reset, then lock from edge 1: release at edge 1027, strobes at +768, +1536
    add(1, 0, 0, 2,    1, 0, 0, 8'd0, "reset_state");
    add(0, 1, 0, 1026, 1, 0, 0, 8'd0, "pre_release_1026");
    add(0, 1, 0, 1,    0, 0, 0, 8'd0, "release_1027");
    add(0, 1, 0, 767,  0, 0, 0, 8'd0, "ce_before_first");
    add(0, 1, 0, 1,    0, 1, 0, 8'd0, "ce_first");
    add(0, 1, 0, 1,    0, 0, 0, 8'd0, "ce_one_cycle");
    add(0, 1, 0, 766,  0, 0, 0, 8'd0, "ce_gap");
    add(0, 1, 0, 1,    0, 1, 0, 8'd0, "ce_second");
    // one-cycle lock drop in RUN: core_rst rises SYNC_STAGES+1 edges later
    add(0, 0, 0, 1,    0, 0, 0, 8'd0, "loss_edge1");
    add(0, 1, 0, 1,    0, 0, 0, 8'd0, "loss_edge2");
    add(0, 1, 0, 1,    1, 0, 1, LC,   "loss_edge3");
    add(0, 1, 0, 1024, 1, 0, 1, LC,   "relock_hold");
    add(0, 1, 0, 1,    0, 0, 1, LC,   "relock_release");
    add(0, 1, 1, 1,    0, 0, 0, 8'd0, "clr_lost");
    // loss event coinciding with clr_lost: set wins
    add(0, 0, 0, 1,    0, 0, 0, 8'd0, "loss_clr_e1");
    add(0, 1, 0, 1,    0, 0, 0, 8'd0, "loss_clr_e2");
    add(0, 1, 1, 1,    1, 0, 1, LC,   "loss_and_clr");
    add(0, 1, 0, 1024, 1, 0, 1, LC,   "relock2_hold");
    add(0, 1, 0, 1,    0, 0, 1, LC,   "relock2_release");
    add(0, 1, 0, 10,   0, 0, 1, LC,   "run_idle");
    // reset during RUN
    add(1, 1, 0, 1,    1, 0, 0, 8'd0, "rst_in_run");
    add(0, 1, 0, 1026, 1, 0, 0, 8'd0, "rst_rel_hold");
    add(0, 1, 0, 1,    0, 0, 0, 8'd0, "rst_rel_release");
    // short lock drop while STABLE restarts the count
    add(1, 0, 0, 1,    1, 0, 0, 8'd0, "abort_reset");
    add(0, 1, 0, 500,  1, 0, 0, 8'd0, "abort_lock500");
    add(0, 0, 0, 3,    1, 0, 0, 8'd0, "abort_drop3");
    add(0, 1, 0, 1026, 1, 0, 0, 8'd0, "abort_hold");
    add(0, 1, 0, 1,    0, 0, 0, 8'd0, "abort_release");
  end

  initial begin
    @(negedge clk);
    fork
      begin : big_thread
        foreach (tbl[k]) begin
          rst = tbl[k].rst; locked = tbl[k].locked; clr_lost = tbl[k].clr;
          repeat (tbl[k].n) @(negedge clk);
          check({tbl[k].name, ".core_rst"},  {31'd0, core_rst},  {31'd0, tbl[k].e_rst});
          check({tbl[k].name, ".sample_ce"}, {31'd0, sample_ce}, {31'd0, tbl[k].e_ce});
          check({tbl[k].name, ".lock_lost"}, {31'd0, lock_lost}, {31'd0, tbl[k].e_lost});
          check({tbl[k].name, ".lost_count"}, {24'd0, lost_count}, {24'd0, tbl[k].e_cnt});
        end
      end
      begin : small_thread
        s_rst = 1'b1; s_locked = 1'b0; s_clr = 1'b0;
        repeat (2) begin @(negedge clk); cmp_small(); end
        s_rst = 1'b0;
        // randomized lock patterns with occasional clears and resets
        for (int seg = 0; seg < 400; seg++) begin
          int hi, lo;
          hi = $urandom_range(1, 25);
          lo = $urandom_range(1, 3);
          for (int c = 0; c < hi + lo; c++) begin
            s_locked = (c < hi);
            s_clr    = ($urandom_range(0, 7) == 0);
            s_rst    = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            cmp_small();
          end
        end
        // saturation: 300 loss events
        s_clr = 1'b0; s_rst = 1'b1;
        @(negedge clk); cmp_small();
        s_rst = 1'b0;
        for (int e = 0; e < 300; e++) begin
          s_locked = 1'b1;
          repeat (12) begin @(negedge clk); cmp_small(); end
          s_locked = 1'b0;
          @(negedge clk); cmp_small();
        end
        s_locked = 1'b1;
        repeat (SS + 2) begin @(negedge clk); cmp_small(); end
        check("sat_lost_count", {24'd0, s_lost_count}, (CNT_EN != 0) ? 32'd255 : 32'd0);
        check("sat_lock_lost",  {31'd0, s_lock_lost}, 32'd1);
        check("sat_core_rst",   {31'd0, s_core_rst},  32'd1);
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2: number of synchronizer flops on locked (legal 2..4).
REQ-002 SHALL provide parameter STABLE_CYCLES, default 1024: consecutive lock cycles required before core reset release (legal 2..65536).
REQ-003 SHALL provide parameter CE_DIV, default 768: clk cycles per sample_ce pulse; 33.8688 MHz / 768 = 44.1 kHz.
REQ-004 SHALL have port clk, input, 1: the single clock, PLL outclk_0 domain (33.8688 MHz).
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port locked, input, 1: PLL lock indicator, asynchronous to clk.
REQ-007 SHALL have port clr_lost, input, 1: synchronous clear of the lock-loss status.
REQ-008 SHALL have port core_rst, output, 1: registered active-high reset for the downstream core.
REQ-009 SHALL have port sample_ce, output, 1: registered one-cycle clock-enable strobe at the audio sample rate.
REQ-010 SHALL have port lock_lost, output, 1: sticky flag, set when lock drops while in RUN.
REQ-011 SHALL have port lost_count, output, 8: saturating lock-loss counter (see Configuration).

Function
REQ-012 SHALL pass locked through SYNC_STAGES flops in series; the last flop is lock_s, and only lock_s is used internally.
REQ-013 SHALL implement FSM states WAIT_LOCK, STABLE and RUN.
REQ-014 WAIT_LOCK: core_rst=1; lock_s=1 -> STABLE with the stability counter cleared to 0.
REQ-015 STABLE: counter increments each cycle; lock_s=0 -> WAIT_LOCK (counter discarded); counter==STABLE_CYCLES-1 with lock_s=1 -> RUN.
REQ-016 SHALL deassert core_rst on the same edge that enters RUN; core_rst falls at the (SYNC_STAGES+STABLE_CYCLES+1)th edge, counting the first edge that samples locked=1 as edge 1.
REQ-017 RUN: lock_s=0 -> WAIT_LOCK, and core_rst=1 on that same edge (no glitch-free window).
REQ-018 SHALL clear the sample divider to 0 on RUN entry; it counts 0..CE_DIV-1 and wraps.
REQ-019 SHALL drive sample_ce=1 for exactly one cycle when the divider equals CE_DIV-1; sample_ce=0 in all states other than RUN.
REQ-020 First sample_ce SHALL occur CE_DIV cycles after core_rst falls, then every CE_DIV cycles with no drift.
REQ-021 RUN->WAIT_LOCK transition SHALL set lock_lost; clr_lost clears lock_lost; when both occur in the same cycle, set wins.
REQ-022 Counter widths SHALL be clog2 of their terminal values; no overflow at maximum legal parameters.

Reset
REQ-023 rst=1 SHALL force on the next edge: all synchronizer flops=0, state=WAIT_LOCK, counters=0, core_rst=1, sample_ce=0, lock_lost=0, lost_count=0.
REQ-024 rst asserted mid-STABLE or mid-RUN SHALL abort immediately; the full SYNC_STAGES+STABLE_CYCLES sequence is required again after release.
REQ-025 rst SHALL have priority over clr_lost and over all FSM transitions.

Configuration
REQ-026 With macro PLL_SEQ_LOSS_CNT_EN defined: lost_count increments on each RUN->WAIT_LOCK transition, saturates at 255, and clears on clr_lost (increment wins when simultaneous).
REQ-027 Without PLL_SEQ_LOSS_CNT_EN: lost_count is tied to 8'd0 and no counter logic is built; lock_lost behaviour is unchanged.

Verification
REQ-028 Defaults; rst released, locked=1 from cycle 0 -> core_rst falls at edge 1027; first sample_ce 768 cycles later; next pulse +768.
REQ-029 locked=1 for 500 cycles, 0 for 3, then 1 -> core_rst remains high; release occurs 1027 edges after re-assertion.
REQ-030 In RUN, locked drops for 1 cycle -> core_rst=1 within SYNC_STAGES+1 edges, sample_ce stops, lock_lost=1, lost_count=1 (macro defined) or 0 (undefined).
REQ-031 Same-cycle loss event and clr_lost -> lock_lost=1; with macro, 300 loss events -> lost_count=255.
REQ-032 rst pulsed during RUN with locked=1 -> core_rst=1 and all flags 0 next edge; release again after 1027 edges.
